ddr_rd_arbiter: RTL and testbench

- Shares the single DDR read port between N_REQ requesters: event-driven weight fetch, neuron-state fetch, and others.
- Round-robin arbitration; one burst owns the port from command issue until its last data beat.
- Issues the read command, counts returned beats, tags each beat with the owner index, and pulses a per-requester done.
- Sits between the core-processing controllers (which raise a request in their DDR-prepare state and wait for done) and the DDR read interface.

---
 rtl/ddr_rd_arbiter.sv | 142 ++++++++++++++
 tb/tb_ddr_rd_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_arbiter.sv
// Round-robin owner of the shared DDR read port: one burst at a time from
// command issue to last data beat, with per-beat owner tags and done pulses.
//
// state | meaning
// IDLE  | no request pending, port free
// ARB   | pick next requester from the RR pointer, latch its addr/len
// CMD   | read command presented to DDR until accepted
// DATA  | forwarding returned beats until len beats seen
// DONE  | pulse done for the owner, advance the RR pointer
module ddr_rd_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8,
    parameter int DATA_W = 128
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*LEN_W-1:0]    req_len,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rd_done,
    output logic                      ddr_cmd_valid,
    input  logic                      ddr_cmd_ready,
    output logic [ADDR_W-1:0]         ddr_cmd_addr,
    output logic [LEN_W-1:0]          ddr_cmd_len,
    input  logic                      ddr_rd_valid,
    input  logic [DATA_W-1:0]         ddr_rd_data,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(N_REQ)-1:0]  out_owner,
    output logic                      busy
);
    localparam int OW = $clog2(N_REQ);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARB  = 3'd1;
    localparam logic [2:0] S_CMD  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic [OW-1:0]    rr_ptr;
    logic [OW-1:0]    owner;
    logic [OW-1:0]    owner_inc;
    logic [OW-1:0]    arb_sel;
    logic             arb_found;
    logic [OW:0]      scan_idx;
    logic [LEN_W-1:0] arb_len;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] cnt_inc;

    // Scan downward so the candidate closest to the pointer is written last and wins.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        scan_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr} + (OW+1)'(k);
            if (scan_idx >= (OW+1)'(N_REQ))
                scan_idx = scan_idx - (OW+1)'(N_REQ);
            if (req[scan_idx[OW-1:0]]) begin
                arb_found = 1'b1;
                arb_sel   = scan_idx[OW-1:0];
            end
        end
    end

    assign arb_len   = req_len[arb_sel*LEN_W +: LEN_W];
    assign owner_inc = (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign cnt_inc   = beat_cnt + 1'b1;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            beat_cnt      <= '0;
            gnt           <= '0;
            rd_done       <= '0;
            ddr_cmd_valid <= 1'b0;
            ddr_cmd_addr  <= '0;
            ddr_cmd_len   <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_owner     <= '0;
        end else begin
            out_valid <= 1'b0;
            rd_done   <= '0;
            case (state)
                S_IDLE: begin
                    if (|req)
                        state <= S_ARB;
                end
                S_ARB: begin
                    if (arb_found) begin
                        owner        <= arb_sel;
                        gnt          <= N_REQ'(1) << arb_sel;
                        ddr_cmd_addr <= req_addr[arb_sel*ADDR_W +: ADDR_W];
                        ddr_cmd_len  <= arb_len;
                        if (arb_len == '0) begin
                            rd_done <= N_REQ'(1) << arb_sel;
                            state   <= S_DONE;
                        end else begin
                            ddr_cmd_valid <= 1'b1;
                            state         <= S_CMD;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CMD: begin
                    if (ddr_cmd_ready) begin
                        ddr_cmd_valid <= 1'b0;
                        beat_cnt      <= '0;
                        state         <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (ddr_rd_valid) begin
                        beat_cnt  <= cnt_inc;
                        out_valid <= 1'b1;
                        out_data  <= ddr_rd_data;
                        out_owner <= owner;
                        if (cnt_inc == ddr_cmd_len) begin
                            rd_done <= gnt;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Owner's own req is masked: it is still dropping it this cycle.
                    gnt    <= '0;
                    rr_ptr <= owner_inc;
                    state  <= (|(req & ~gnt)) ? S_ARB : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Bench for ddr_rd_arbiter: directed scenarios followed by randomized bursts
// checked against a transaction-level round-robin model.
module tb_ddr_rd_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 8;
    localparam int DW = 128;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rd_done;
    logic            ddr_cmd_valid;
    logic            ddr_cmd_ready;
    logic [AW-1:0]   ddr_cmd_addr;
    logic [LW-1:0]   ddr_cmd_len;
    logic            ddr_rd_valid;
    logic [DW-1:0]   ddr_rd_data;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_owner;
    logic            busy;

    int checks = 0;
    int errors = 0;

    // expected outcome of the cycle being stepped
    logic          beat_pend;
    logic [DW-1:0] beat_data;
    logic [1:0]    beat_own;
    logic [N-1:0]  done_exp;

    // requester-side model
    logic [N-1:0]  pend;
    logic [AW-1:0] m_addr [N];
    logic [LW-1:0] m_len  [N];
    int            mptr;

    always #5 CLK = ~CLK;

    ddr_rd_arbiter #(.N_REQ(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST_N(RST_N), .req(req), .req_addr(req_addr), .req_len(req_len),
        .gnt(gnt), .rd_done(rd_done), .ddr_cmd_valid(ddr_cmd_valid),
        .ddr_cmd_ready(ddr_cmd_ready), .ddr_cmd_addr(ddr_cmd_addr), .ddr_cmd_len(ddr_cmd_len),
        .ddr_rd_valid(ddr_rd_valid), .ddr_rd_data(ddr_rd_data), .out_valid(out_valid),
        .out_data(out_data), .out_owner(out_owner), .busy(busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit chk_done = 1'b1);
        @(posedge CLK);
        #1;
        chk("out_valid", out_valid, beat_pend);
        if (beat_pend) begin
            chk("out_data", out_data, beat_data);
            chk("out_owner", out_owner, beat_own);
        end
        if (chk_done)
            chk("rd_done", rd_done, done_exp);
        beat_pend    = 1'b0;
        done_exp     = '0;
        ddr_rd_valid = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_addr[i*AW +: AW] = a;
        req_len[i*LW +: LW]  = l;
        req[i]    = 1'b1;
        pend[i]   = 1'b1;
        m_addr[i] = a;
        m_len[i]  = l;
    endtask

    task automatic release_req(input int own);
        req[own]  = 1'b0;
        pend[own] = 1'b0;
        mptr      = (own + 1) % N;
    endtask

    task automatic beat(input int own, input bit last);
        ddr_rd_valid = 1'b1;
        ddr_rd_data  = {$urandom, $urandom, $urandom, $urandom};
        beat_pend    = 1'b1;
        beat_data    = ddr_rd_data;
        beat_own     = 2'(own);
        if (last)
            done_exp = 4'b0001 << own;
        tick();
    endtask

    task automatic stray();
        ddr_rd_valid = 1'b1;
        ddr_rd_data  = {$urandom, $urandom, $urandom, $urandom};
        tick();
    endtask

    task automatic wait_evt(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 16 && !ok) begin
            tick(1'b0);
            n++;
            ok = ddr_cmd_valid || (rd_done != '0);
        end
    endtask

    function automatic int rr_pick();
        for (int k = 0; k < N; k++)
            if (pend[(mptr + k) % N])
                return (mptr + k) % N;
        return -1;
    endfunction

    task automatic do_burst(input int own, input int bp, input int maxgap);
        bit ok;
        int len;
        len = int'(m_len[own]);
        ddr_cmd_ready = 1'b0;
        wait_evt(ok);
        chk("evt_seen", ok, 1);
        chk("gnt", gnt, 4'b0001 << own);
        if (len == 0) begin
            chk("zero_len_done", rd_done, 4'b0001 << own);
            chk("zero_len_nocmd", ddr_cmd_valid, 0);
        end else begin
            chk("cmd_valid", ddr_cmd_valid, 1);
            chk("cmd_addr", ddr_cmd_addr, m_addr[own]);
            chk("cmd_len", ddr_cmd_len, m_len[own]);
            for (int i = 0; i < bp; i++) begin
                tick();
                chk("bp_valid", ddr_cmd_valid, 1);
                chk("bp_addr", ddr_cmd_addr, m_addr[own]);
            end
            ddr_cmd_ready = 1'b1;
            tick();
            ddr_cmd_ready = 1'b0;
            chk("cmd_accepted", ddr_cmd_valid, 0);
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(maxgap)) tick();
                beat(own, b == len - 1);
            end
        end
        release_req(own);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        RST_N = 1'b1;
        req = '0; req_addr = '0; req_len = '0;
        ddr_cmd_ready = 1'b0; ddr_rd_valid = 1'b0; ddr_rd_data = '0;
        beat_pend = 1'b0; beat_data = '0; beat_own = '0; done_exp = '0;
        pend = '0; mptr = 0;
        for (int i = 0; i < N; i++) begin m_addr[i] = '0; m_len[i] = '0; end
        #2 RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", rd_done, 0);
        chk("rst_cmd_valid", ddr_cmd_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_owner", out_owner, 0);
        chk("rst_cmd_addr", ddr_cmd_addr, 0);
        chk("rst_cmd_len", ddr_cmd_len, 0);
        chk("rst_busy", busy, 0);
        RST_N = 1'b1;

        // single requester, command two cycles after req
        ddr_cmd_ready = 1'b1;
        set_req(1, 32'h1000, 8'd4);
        tick();
        chk("t1_busy", busy, 1);
        chk("t1_arb_nocmd", ddr_cmd_valid, 0);
        tick();
        chk("t1_cmd_valid", ddr_cmd_valid, 1);
        chk("t1_cmd_addr", ddr_cmd_addr, 32'h1000);
        chk("t1_cmd_len", ddr_cmd_len, 4);
        chk("t1_gnt", gnt, 4'b0010);
        tick();
        chk("t1_cmd_drop", ddr_cmd_valid, 0);
        for (int b = 0; b < 4; b++) beat(1, b == 3);
        release_req(1);
        tick();
        chk("t1_idle", busy, 0);
        chk("t1_gnt_clr", gnt, 0);

        // zero length: done two cycles after req, no command
        set_req(2, 32'h2000, 8'd0);
        tick();
        chk("t2_busy", busy, 1);
        done_exp = 4'b0100;
        tick();
        chk("t2_nocmd", ddr_cmd_valid, 0);
        chk("t2_gnt", gnt, 4'b0100);
        release_req(2);
        tick();
        chk("t2_nocmd2", ddr_cmd_valid, 0);
        chk("t2_idle", busy, 0);

        // backpressure: ready low for 5 cycles, beats during CMD dropped
        ddr_cmd_ready = 1'b0;
        set_req(0, 32'h3000, 8'd2);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid_held", ddr_cmd_valid, 1);
            chk("t3_addr_stable", ddr_cmd_addr, 32'h3000);
            chk("t3_len_stable", ddr_cmd_len, 2);
            if (i < 4) stray();
        end
        ddr_cmd_ready = 1'b1;
        tick();
        chk("t3_cmd_drop", ddr_cmd_valid, 0);
        beat(0, 1'b0);
        beat(0, 1'b1);
        release_req(0);
        tick();
        chk("t3_idle", busy, 0);

        // stray beats in IDLE, then a gapped len=3 burst
        stray();
        stray();
        set_req(3, 32'h4000, 8'd3);
        tick();
        tick();
        chk("t4_gnt", gnt, 4'b1000);
        chk("t4_cmd_addr", ddr_cmd_addr, 32'h4000);
        tick();
        for (int b = 0; b < 3; b++) begin
            beat(3, b == 2);
            if (b < 2) begin tick(); tick(); end
        end
        release_req(3);
        tick();
        chk("t4_idle", busy, 0);

        // round robin with all requesters re-requesting
        for (int i = 0; i < N; i++) set_req(i, 32'h5000 + 32'(i * 64), 8'd1);
        for (int g = 0; g < 5; g++) begin
            do_burst(g % N, 0, 0);
            if (g < 4) set_req(g % N, 32'h6000 + 32'(g * 64), 8'd1);
            else begin req = '0; pend = '0; end
        end

        // maximum burst length
        set_req(0, 32'h7000, 8'd255);
        do_burst(rr_pick(), 0, 0);

        // reset in the middle of DATA
        set_req(2, 32'h8000, 8'd0);
        do_burst(rr_pick(), 0, 0);
        set_req(3, 32'h9000, 8'd8);
        ddr_cmd_ready = 1'b0;
        wait_evt(ok);
        chk("t6_evt", ok, 1);
        chk("t6_gnt", gnt, 4'b1000);
        ddr_cmd_ready = 1'b1;
        tick();
        ddr_cmd_ready = 1'b0;
        beat(3, 1'b0);
        beat(3, 1'b0);
        RST_N = 1'b0;
        req = '0; pend = '0; mptr = 0;
        #2;
        chk("t6_gnt_rst", gnt, 0);
        chk("t6_ov_rst", out_valid, 0);
        chk("t6_busy_rst", busy, 0);
        chk("t6_od_rst", out_data, 0);
        chk("t6_cmd_rst", ddr_cmd_valid, 0);
        tick();
        tick();
        RST_N = 1'b1;
        stray();
        stray();
        set_req(3, 32'hA000, 8'd1);
        set_req(2, 32'hB000, 8'd1);
        do_burst(rr_pick(), 1, 1);
        do_burst(rr_pick(), 1, 1);

        // randomized traffic
        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(1) == 1)
                    set_req(i, $urandom, 8'($urandom_range(6)));
            if (pend == '0)
                set_req(int'($urandom_range(N - 1)), $urandom, 8'($urandom_range(6)));
            do_burst(rr_pick(), int'($urandom_range(3)), int'($urandom_range(2)));
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
